// File: rtl/ram_arb_pkg.sv
// Shared encodings for the instruction/data SRAM arbiter: FSM states, port IDs
// and access-size codes.
package ram_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_OWN_I = 4'b0010,
    ST_OWN_D = 4'b0100,
    ST_DRAIN = 4'b1000
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [1:0] HB_WORD = 2'b10;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_BYTE = 2'b00;

  function automatic state_e own_state(logic port);
    return (port == PORT_D) ? ST_OWN_D : ST_OWN_I;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the SRAM arbiter. With RAM_ARB_RR_EN defined a
// contended pick goes to the port that did not own last; otherwise D beats I.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef RAM_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = i_req | d_req;
    winner = d_req ? PORT_D : PORT_I;
`ifdef RAM_ARB_RR_EN
    if (i_req && d_req) begin
      winner = ~last_owner;
    end
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port SRAM between the fetch (I) and load/store (D) ports.
// Build option: RAM_ARB_RR_EN selects round-robin instead of fixed D>I priority.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; arbitrate pending requests, SRAM request low
// ST_OWN_I | fetch port owns the SRAM until grant or abort
// ST_OWN_D | load/store port owns the SRAM until grant or abort
// ST_DRAIN | aborted transfer; SRAM idle for DRAIN_CYCLES so its FSM resets
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic [31:0]       i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [1:0]        d_hb_i,
  input  logic              d_uload_i,
  output logic              d_gnt_o,
  output logic [31:0]       d_rdata_o,
  output logic              ram_ce_o,
  output logic              ram_req_o,
  input  logic              ram_gnt_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [1:0]        ram_hb_o,
  output logic              ram_uload_o,
  input  logic [31:0]       ram_rdata_i
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic               pick_valid;
  logic               pick_winner;

`ifdef RAM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= PORT_I;
    end else if (i_gnt_o) begin
      last_q <= PORT_I;
    end else if (d_gnt_o) begin
      last_q <= PORT_D;
    end
  end
`endif

  ram_arb_pick u_pick (
    .i_req      (i_req_i),
    .d_req      (d_req_i),
`ifdef RAM_ARB_RR_EN
    .last_owner (last_q),
`endif
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    ram_ce_o    = 1'b0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_hb_o    = HB_BYTE;
    ram_uload_o = 1'b0;
    i_gnt_o     = 1'b0;
    i_rdata_o   = '0;
    d_gnt_o     = 1'b0;
    d_rdata_o   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = own_state(pick_winner);
        end
      end

      // Fetch is always a read of a full word.
      ST_OWN_I: begin
        ram_ce_o   = 1'b1;
        ram_req_o  = i_req_i;
        ram_addr_o = i_addr_i;
        ram_hb_o   = HB_WORD;
        i_gnt_o    = ram_gnt_i;
        i_rdata_o  = ram_rdata_i;
        if (ram_gnt_i) begin
          state_d = ST_IDLE;
        end else if (!i_req_i) begin
          state_d = ST_DRAIN;
          drain_d = CNT_W'(DRAIN_CYCLES);
        end
      end

      ST_OWN_D: begin
        ram_ce_o    = 1'b1;
        ram_req_o   = d_req_i;
        ram_we_o    = d_we_i;
        ram_addr_o  = d_addr_i;
        ram_wdata_o = d_wdata_i;
        ram_hb_o    = d_hb_i;
        ram_uload_o = d_uload_i;
        d_gnt_o     = ram_gnt_i;
        d_rdata_o   = ram_rdata_i;
        if (ram_gnt_i) begin
          state_d = ST_IDLE;
        end else if (!d_req_i) begin
          state_d = ST_DRAIN;
          drain_d = CNT_W'(DRAIN_CYCLES);
        end
      end

      ST_DRAIN: begin
        if (drain_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          drain_d = '0;
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: SRAM model (IDLE/BUSY/RSTS), an
// owner-level arbiter model checked every cycle, and directed scenarios.
module tb_ram_arbiter;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_uload, d_gnt;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_hb;
  logic        ram_ce, ram_req, ram_gnt, ram_we, ram_uload;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  ram_hb;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_hb_i(d_hb), .d_uload_i(d_uload), .d_gnt_o(d_gnt), .d_rdata_o(d_rdata),
    .ram_ce_o(ram_ce), .ram_req_o(ram_req), .ram_gnt_i(ram_gnt), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_hb_o(ram_hb),
    .ram_uload_o(ram_uload), .ram_rdata_i(ram_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // SRAM model: accepts in IDLE, grants in RSTS two cycles later; contents reload on reset.
  logic [31:0] mem [64];
  int          s_st;

  function automatic logic [31:0] sram_read(logic [31:0] w, logic [1:0] a, logic [1:0] hb, logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    if (hb == 2'b10) return w;
    if (hb == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
    return u ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  assign ram_gnt   = (s_st == 2) && ram_ce && ram_req;
  assign ram_rdata = (s_st == 2) ? sram_read(mem[ram_addr[7:2]], ram_addr[1:0], ram_hb, ram_uload) : 32'h0;

  always @(posedge clk) begin
    if (!rst_n) begin
      s_st <= 0;
      for (int k = 0; k < 64; k++) mem[k] <= {16'hC0DE, 16'(k)};
    end else begin
      case (s_st)
        0: if (ram_ce && ram_req) s_st <= 1;
        1: s_st <= 2;
        default: s_st <= 0;
      endcase
      if (ram_gnt && ram_we) begin
        if (ram_hb == 2'b10) mem[ram_addr[7:2]] <= ram_wdata;
        else if (ram_hb == 2'b01) mem[ram_addr[7:2]][16*ram_addr[1] +: 16] <= ram_wdata[15:0];
        else mem[ram_addr[7:2]][8*ram_addr[1:0] +: 8] <= ram_wdata[7:0];
      end
    end
  end

  // Owner-level model: owner 0=none 1=I 2=D, drain = idle cycles left after an abort.
  int m_owner, m_drain;
  bit m_last_d;

  function automatic int m_pick(bit ir, bit dr, bit last_d);
    bit rr;
`ifdef RAM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    if (ir && dr) return (rr && last_d) ? 1 : 2;
    return dr ? 2 : 1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner  <= 0;
      m_drain  <= 0;
      m_last_d <= 1'b0;
    end else if (m_drain > 0) begin
      m_drain <= m_drain - 1;
    end else if (m_owner == 0) begin
      if (i_req || d_req) m_owner <= m_pick(i_req, d_req, m_last_d);
    end else if (ram_gnt) begin
      m_owner  <= 0;
      m_last_d <= (m_owner == 2);
    end else if (!((m_owner == 1) ? i_req : d_req)) begin
      m_owner <= 0;
      m_drain <= DRAIN;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit          oi, od;
      logic [31:0] e_ctl, a_ctl;
      oi    = (m_owner == 1);
      od    = (m_owner == 2);
      e_ctl = {26'h0, (oi || od), oi ? i_req : (od ? d_req : 1'b0), od && d_we,
               oi ? 2'b10 : (od ? d_hb : 2'b00), od && d_uload};
      a_ctl = {26'h0, ram_ce, ram_req, ram_we, ram_hb, ram_uload};
      chk("cyc_ram_ctl", a_ctl, e_ctl);
      chk("cyc_ram_addr", ram_addr, oi ? i_addr : (od ? d_addr : 32'h0));
      chk("cyc_ram_wdata", ram_wdata, od ? d_wdata : 32'h0);
      chk("cyc_i_gnt", {31'h0, i_gnt}, {31'h0, ram_gnt && oi});
      chk("cyc_d_gnt", {31'h0, d_gnt}, {31'h0, ram_gnt && od});
      chk("cyc_i_rdata", i_rdata, oi ? ram_rdata : 32'h0);
      chk("cyc_d_rdata", d_rdata, od ? ram_rdata : 32'h0);
      chk("cyc_one_grant", {31'h0, i_gnt && d_gnt}, 32'h0);
    end
  end

  logic [31:0] i_cap, d_cap, d_cap_addr;
  logic [1:0]  d_cap_hb;
  int          ce_low;

  task automatic set_i(input logic [31:0] a);
    i_addr = a;
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] hb, input logic u);
    d_we = we; d_addr = a; d_wdata = wd; d_hb = hb; d_uload = u;
  endtask

  // Raises requests at the given cycle indices (negative = unused), drops each
  // after its grant; grant indices count from the first cycle (-1 = none).
  task automatic run_xfer(input int i_start, input int d_start, input int d_abort,
                          output int ig, output int dg);
    bit i_done, d_done;
    i_done = (i_start < 0);
    d_done = (d_start < 0);
    ig = -1; dg = -1; ce_low = 0;
    for (int n = 0; n < 40; n++) begin
      if (n == i_start) i_req = 1'b1;
      if (n == d_start) d_req = 1'b1;
      if (n == d_abort) begin d_req = 1'b0; d_done = 1'b1; end
      @(negedge clk);
      if (!ram_ce) ce_low++;
      if (i_gnt && ig < 0) begin ig = n; i_cap = i_rdata; i_done = 1'b1; end
      if (d_gnt && dg < 0) begin
        dg = n; d_cap = d_rdata; d_cap_addr = ram_addr; d_cap_hb = ram_hb; d_done = 1'b1;
      end
      @(posedge clk); #1;
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
      if (i_done && d_done) break;
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ig, dg;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
    set_i(32'h0);
    set_d(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    @(negedge clk);
    chk("reset_ce", {31'h0, ram_ce}, 32'h0);
    chk("reset_addr", ram_addr, 32'h0);
    chk("reset_gnts", {30'h0, i_gnt, d_gnt}, 32'h0);
    @(posedge clk); #1;

    // I-only fetch from reset
    set_i(32'h10);
    run_xfer(0, -1, -1, ig, dg);
    chk("t1_i_gnt_cycle", 32'(ig), 32'd3);
    chk("t1_i_rdata", i_cap, 32'hC0DE0004);
    chk("t1_no_d_gnt", 32'(dg), 32'hFFFFFFFF);

    // D word write then fetch back
    set_d(1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0);
    run_xfer(-1, 0, -1, ig, dg);
    chk("t2_d_gnt_cycle", 32'(dg), 32'd3);
    set_i(32'h20);
    run_xfer(0, -1, -1, ig, dg);
    chk("t2_i_gnt_cycle", 32'(ig), 32'd3);
    chk("t2_i_rdata", i_cap, 32'hDEADBEEF);

    // Contended rounds, last owner I before each
    set_i(32'h04);
    set_d(1'b0, 32'h08, 32'h0, 2'b10, 1'b0);
    run_xfer(0, 0, -1, ig, dg);
    chk("t3_r1_d_first", 32'(dg), 32'd3);
    chk("t3_r1_i_next", 32'(ig), 32'd7);
    chk("t3_r1_d_rdata", d_cap, 32'hC0DE0002);
    run_xfer(0, 0, -1, ig, dg);
    chk("t3_r2_d_first", 32'(dg), 32'd3);
    chk("t3_r2_i_next", 32'(ig), 32'd7);

    // D owned last: round-robin hands the contended round to I
    run_xfer(-1, 0, -1, ig, dg);
    run_xfer(0, 0, -1, ig, dg);
`ifdef RAM_ARB_RR_EN
    chk("t3_r3_i_first", 32'(ig), 32'd3);
    chk("t3_r3_d_next", 32'(dg), 32'd7);
`else
    chk("t3_r3_d_first", 32'(dg), 32'd3);
    chk("t3_r3_i_next", 32'(ig), 32'd7);
`endif

    // D aborts one cycle into OWN_D while I waits
    set_i(32'h10);
    set_d(1'b0, 32'h0C, 32'h0, 2'b10, 1'b0);
    run_xfer(1, 0, 2, ig, dg);
    chk("t4_no_d_gnt", 32'(dg), 32'hFFFFFFFF);
    chk("t4_i_gnt_cycle", 32'(ig), 32'd8);
    chk("t4_ce_low_cycles", 32'(ce_low), 32'd4);
    chk("t4_i_rdata", i_cap, 32'hC0DE0004);

    // Reset during OWN_I
    set_i(32'h10);
    i_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_own_ce", {31'h0, ram_ce}, 32'h1);
    chk("t5_no_gnt_rst", {31'h0, i_gnt}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("t5_after_ce", {30'h0, ram_ce, ram_req}, 32'h0);
    chk("t5_after_addr", ram_addr, 32'h0);
    chk("t5_after_gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
    @(posedge clk); #1;
    run_xfer(0, -1, -1, ig, dg);
    chk("t5_fresh_gnt", 32'(ig), 32'd3);
    chk("t5_fresh_rdata", i_cap, 32'hC0DE0004);

    // Byte store while I keeps requesting, then read it back three ways
    set_i(32'h30);
    set_d(1'b1, 32'h33, 32'h000000AB, 2'b00, 1'b0);
    run_xfer(1, 0, -1, ig, dg);
    chk("t6_d_gnt_cycle", 32'(dg), 32'd3);
    chk("t6_i_gnt_cycle", 32'(ig), 32'd7);
    chk("t6_hb", {30'h0, d_cap_hb}, 32'h0);
    chk("t6_addr", d_cap_addr, 32'h33);
    chk("t6_i_word", i_cap, 32'hABDE000C);
    set_d(1'b0, 32'h33, 32'h0, 2'b00, 1'b1);
    run_xfer(-1, 0, -1, ig, dg);
    chk("t6_lbu", d_cap, 32'h000000AB);
    set_d(1'b0, 32'h33, 32'h0, 2'b00, 1'b0);
    run_xfer(-1, 0, -1, ig, dg);
    chk("t6_lb", d_cap, 32'hFFFFFFAB);
    set_d(1'b0, 32'h32, 32'h0, 2'b01, 1'b1);
    run_xfer(-1, 0, -1, ig, dg);
    chk("t6_lhu", d_cap, 32'h0000ABDE);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
